// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan driver with double-buffered page capture, prescaled refresh and frame pulse.
// Optional leading-zero blanking is compiled in when DISP_ZERO_BLANK_EN is defined.
module disp_scan_ctrl #(
  parameter  int DIGITS      = 4,
  parameter  int PAGES       = 2,
  parameter  int SCAN_DIV    = 50000,
  parameter  int SEG_ACT_LOW = 0,
  localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS*PAGES-1:0] data_i,
  input  logic [PW-1:0]             page_i,
  input  logic [DIGITS-1:0]         dp_i,
  input  logic                      load_i,
  input  logic                      blank_i,
  output logic [7:0]                seg_o,
  output logic [DIGITS-1:0]         sel_o,
  output logic                      frame_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NW = 4 * DIGITS;
  localparam logic [7:0]        SEG_INV = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_INV = (SEG_ACT_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] SEL_RST = DIGITS'(1) ^ SEL_INV;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] sel_q;
  logic [7:0]        seg_q;
  logic              frame_q;
  logic [NW-1:0]     pend_data, act_data;
  logic [DIGITS-1:0] pend_dp, act_dp;
  logic              pend_flag;

  logic              tick, wrap, load_ok;
  logic [NW-1:0]     load_data, act_data_nxt;
  logic [DIGITS-1:0] act_dp_nxt, sel_rot;
  logic [IW-1:0]     idx_nxt;
  logic [3:0]        nib;
  logic              dp_bit;
  logic [7:0]        seg_new;

  assign tick      = (cnt == CW'(SCAN_DIV - 1));
  assign wrap      = tick && (idx == IW'(DIGITS - 1));
  assign load_ok   = load_i && (int'(page_i) < PAGES);
  assign load_data = data_i[int'(page_i)*NW +: NW];
  assign idx_nxt   = !tick ? idx : (wrap ? '0 : idx + IW'(1));

  // A load landing on the wrap tick bypasses pending so digit0 of the new frame already shows it
  always_comb begin
    act_data_nxt = act_data;
    act_dp_nxt   = act_dp;
    if (wrap) begin
      if (load_ok) begin
        act_data_nxt = load_data;
        act_dp_nxt   = dp_i;
      end else if (pend_flag) begin
        act_data_nxt = pend_data;
        act_dp_nxt   = pend_dp;
      end
    end
  end

  always_comb begin
    sel_rot = '0;
    for (int i = 0; i < DIGITS; i++) sel_rot[(i + 1) % DIGITS] = sel_q[i];
  end

  assign nib    = act_data_nxt[int'(idx_nxt)*4 +: 4];
  assign dp_bit = act_dp_nxt[idx_nxt];

`ifdef DISP_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;

  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_run     = zero_run && (act_data_nxt[d*4 +: 4] == 4'h0);
      lead_zero[d] = zero_run;
    end
  end

  assign seg_new = blank_i ? 8'h00 : {dp_bit, lead_zero[idx_nxt] ? 7'h00 : hex7(nib)};
`else
  assign seg_new = blank_i ? 8'h00 : {dp_bit, hex7(nib)};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      sel_q     <= SEL_RST;
      seg_q     <= SEG_INV;
      frame_q   <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      cnt      <= tick ? '0 : cnt + CW'(1);
      idx      <= idx_nxt;
      if (tick) sel_q <= sel_rot;
      seg_q    <= seg_new ^ SEG_INV;
      frame_q  <= wrap;
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      if (load_ok) begin
        pend_data <= load_data;
        pend_dp   <= dp_i;
      end
      if (wrap)         pend_flag <= 1'b0;
      else if (load_ok) pend_flag <= 1'b1;
    end
  end

  assign seg_o   = seg_q;
  assign sel_o   = sel_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a time-based reference model of the scan and buffers.
module tb_disp_scan_ctrl;

  localparam int DIGITS      = 4;
  localparam int PAGES       = 3;
  localparam int SCAN_DIV    = 3;
  localparam int SEG_ACT_LOW = 0;
  localparam int PW          = 2;
  localparam int NW          = 4 * DIGITS;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [4*DIGITS*PAGES-1:0] data_i;
  logic [PW-1:0]             page_i;
  logic [DIGITS-1:0]         dp_i;
  logic                      load_i;
  logic                      blank_i;
  logic [7:0]                seg_o;
  logic [DIGITS-1:0]         sel_o;
  logic                      frame_o;

  disp_scan_ctrl #(
    .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV), .SEG_ACT_LOW(SEG_ACT_LOW)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .page_i(page_i), .dp_i(dp_i),
    .load_i(load_i), .blank_i(blank_i), .seg_o(seg_o), .sel_o(sel_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position in the scan is derived from elapsed cycles since reset
  logic [6:0]        seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int                t = 0;
  logic [NW-1:0]     m_pend = '0, m_act = '0;
  logic [DIGITS-1:0] m_pend_dp = '0, m_act_dp = '0;
  bit                m_pend_v = 0;
  logic [7:0]        exp_seg = 8'h00;
  logic [DIGITS-1:0] exp_sel = DIGITS'(1);
  bit                exp_frame = 0;

  function automatic logic [3:0] nib_of(input logic [NW-1:0] v, input int d);
    logic [NW-1:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [7:0] digit_image(input int d);
    bit lead;
    lead = (d != 0);
`ifdef DISP_ZERO_BLANK_EN
    for (int k = DIGITS - 1; k >= d; k--) if (nib_of(m_act, k) != 4'h0) lead = 0;
`else
    lead = 0;
`endif
    return {m_act_dp[d], lead ? 7'h00 : seg_tab[nib_of(m_act, d)]};
  endfunction

  always @(posedge clk) begin
    int  pos;
    bit  tk, wr, ld;
    if (!rst) begin
      t = 0;
      m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0; m_pend_v = 0;
      exp_sel = DIGITS'(1); exp_seg = 8'h00; exp_frame = 0;
    end else begin
      t++;
      tk  = (t % SCAN_DIV) == 0;
      pos = (t / SCAN_DIV) % DIGITS;
      wr  = tk && (pos == 0);
      ld  = load_i && (int'(page_i) < PAGES);
      if (wr) begin
        if (ld) begin
          m_act = data_i[int'(page_i)*NW +: NW]; m_act_dp = dp_i;
        end else if (m_pend_v) begin
          m_act = m_pend; m_act_dp = m_pend_dp;
        end
        m_pend_v = 0;
      end else if (ld) begin
        m_pend = data_i[int'(page_i)*NW +: NW]; m_pend_dp = dp_i; m_pend_v = 1;
      end
      exp_sel   = DIGITS'(1) << pos;
      exp_frame = wr;
      exp_seg   = blank_i ? 8'h00 : digit_image(pos);
    end
  end

  task automatic step();
    @(negedge clk);
    chk("sel",   32'(sel_o),   32'(exp_sel ^ ((SEG_ACT_LOW != 0) ? {DIGITS{1'b1}} : '0)));
    chk("seg",   32'(seg_o),   32'(exp_seg ^ ((SEG_ACT_LOW != 0) ? 8'hFF : 8'h00)));
    chk("frame", 32'(frame_o), 32'(exp_frame));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      load_i = 1'b0; blank_i = 1'b0;
    end
  endtask

  task automatic collect(output logic [7:0] seen [DIGITS]);
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      step();
      for (int d = 0; d < DIGITS; d++) if (sel_o[d]) seen[d] = seg_o;
    end
  endtask

  logic [7:0] seen [DIGITS];

  initial begin
    rst = 1'b0; data_i = '0; page_i = '0; dp_i = '0; load_i = 1'b0; blank_i = 1'b0;
    step(); step();
    chk("rst_sel",   32'(sel_o),   32'h1);
    chk("rst_seg",   32'(seg_o),   32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);
    rst = 1'b1;
    idle(5);

    // page0 = 1A2F loaded mid-frame, visible after the next wrap
    data_i = 48'h0000_0000_1A2F; page_i = 2'd0; load_i = 1'b1;
    idle(2 * DIGITS * SCAN_DIV);
    collect(seen);
    chk("p0_d0", 32'(seen[0]), 32'h71); chk("p0_d1", 32'(seen[1]), 32'h5B);
    chk("p0_d2", 32'(seen[2]), 32'h77); chk("p0_d3", 32'(seen[3]), 32'h06);

    data_i = 48'h0000_BEEF_0000; page_i = 2'd1; load_i = 1'b1;
    step();
    data_i = 48'h1234_5678_9ABC; page_i = 2'd3; load_i = 1'b1;
    idle(2 * DIGITS * SCAN_DIV);
    collect(seen);
    chk("p1_d0", 32'(seen[0]), 32'h71); chk("p1_d1", 32'(seen[1]), 32'h79);
    chk("p1_d2", 32'(seen[2]), 32'h79); chk("p1_d3", 32'(seen[3]), 32'h7C);

    blank_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    blank_i = 1'b0;

    data_i = 48'h0000_0000_0040; page_i = 2'd0; dp_i = 4'b1000; load_i = 1'b1;
    idle(DIGITS * SCAN_DIV + 2);
    rst = 1'b0; step(); rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      step();
      rst     = ($urandom_range(0, 399) != 0);
      load_i  = ($urandom_range(0, 7) == 0);
      page_i  = PW'($urandom_range(0, 3));
      for (int k = 0; k < DIGITS * PAGES; k++)
        data_i[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_i    = DIGITS'($urandom);
      blank_i = ($urandom_range(0, 15) == 0);
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
